// File: rtl/spart_link_if.sv
// Bundles the requester-side and spart_top-side signals of spart_link_ctrl.
// slave is the controller's view; master is the view of whatever drives it.
interface spart_link_if;
  logic [1:0]  req;
  logic [21:0] req_data0;
  logic [21:0] req_data1;
  logic [1:0]  done;
  logic [1:0]  fail;
  logic        send_tx;
  logic [23:0] tx_data;
  logic        tx_busy;
  logic        rx_valid;
  logic [23:0] rx_data;
  logic        rx_msg_valid;
  logic [21:0] rx_msg;
  logic        busy;

  modport slave (
    input  req, req_data0, req_data1, tx_busy, rx_valid, rx_data,
    output done, fail, send_tx, tx_data, rx_msg_valid, rx_msg, busy
  );

  modport master (
    output req, req_data0, req_data1, tx_busy, rx_valid, rx_data,
    input  done, fail, send_tx, tx_data, rx_msg_valid, rx_msg, busy
  );
endinterface

// File: rtl/spart_link_ctrl.sv
// Round-robin TX arbiter with alternating-bit ACK/retransmit framing and an RX duplicate filter for spart_top.
// Defining SPART_LINK_STATS_EN adds saturating stat_retries / stat_drops counters.
module spart_link_ctrl #(
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic        sys_clk,
  input  logic        rst_n,
`ifdef SPART_LINK_STATS_EN
  output logic [15:0] stat_retries,
  output logic [15:0] stat_drops,
`endif
  spart_link_if.slave lnk
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_SAT  = '1;
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_ACK} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_tx_seq;
  logic          r_rx_expect;
  logic          r_rr_ptr;
  logic          r_ack_pending;
  logic          r_ack_seq;
  logic          r_winner;
  logic [21:0]   r_payload;
  logic [TW-1:0] r_timer;
  logic [RW-1:0] r_retries;

  logic          r_send_tx;
  logic [23:0]   r_tx_data;
  logic [1:0]    r_done;
  logic [1:0]    r_fail;
  logic          r_rx_msg_valid;
  logic [21:0]   r_rx_msg;

  logic w_can_issue;
  logic w_rx_ack_match;
  logic w_rx_data_frm;
  logic w_rx_new;
  logic w_timeout;
  logic w_grant_vld;
  logic w_grant;
  logic w_issue_ack;
  logic w_issue_data;
  logic w_done_evt;
  logic w_fail_evt;
  logic w_retry_evt;

  // One launch per two cycles at most, and never while the shifter is busy.
  assign w_can_issue    = !lnk.tx_busy && !r_send_tx;
  assign w_rx_ack_match = lnk.rx_valid && lnk.rx_data[23] && (lnk.rx_data[22] == r_tx_seq);
  assign w_rx_data_frm  = lnk.rx_valid && !lnk.rx_data[23];
  assign w_rx_new       = w_rx_data_frm && (lnk.rx_data[22] == r_rx_expect);
  assign w_timeout      = (r_timer == TIMER_LAST);
  assign w_grant_vld    = |lnk.req;
  assign w_grant        = (&lnk.req) ? ~r_rr_ptr : lnk.req[1];

  always_ff @(posedge sys_clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_grant_vld) w_state_nxt = S_SEND;
      S_SEND:     if (w_issue_data) w_state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (w_done_evt || w_fail_evt) w_state_nxt = S_IDLE;
        else if (w_retry_evt)         w_state_nxt = S_SEND;
      end
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // A matching ACK outranks a timeout landing in the same cycle.
  always_comb begin
    w_issue_ack  = r_ack_pending && w_can_issue;
    w_issue_data = 1'b0;
    w_done_evt   = 1'b0;
    w_fail_evt   = 1'b0;
    w_retry_evt  = 1'b0;
    case (r_state)
      S_SEND:     w_issue_data = w_can_issue && !r_ack_pending;
      S_WAIT_ACK: begin
        if (w_rx_ack_match) w_done_evt = 1'b1;
        else if (w_timeout) begin
          if (r_retries < RETRY_MAX) w_retry_evt = 1'b1;
          else                       w_fail_evt  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_tx_seq       <= 1'b0;
      r_rx_expect    <= 1'b0;
      r_rr_ptr       <= 1'b0;
      r_ack_pending  <= 1'b0;
      r_ack_seq      <= 1'b0;
      r_winner       <= 1'b0;
      r_payload      <= '0;
      r_timer        <= '0;
      r_retries      <= '0;
      r_send_tx      <= 1'b0;
      r_tx_data      <= '0;
      r_done         <= '0;
      r_fail         <= '0;
      r_rx_msg_valid <= 1'b0;
      r_rx_msg       <= '0;
    end else begin
      r_send_tx <= w_issue_ack || w_issue_data;
      if (w_issue_ack)       r_tx_data <= {1'b1, r_ack_seq, 22'd0};
      else if (w_issue_data) r_tx_data <= {1'b0, r_tx_seq, r_payload};

      // A fresh data frame re-arms the ACK even if one is launching this cycle.
      if (w_rx_data_frm) begin
        r_ack_pending <= 1'b1;
        r_ack_seq     <= lnk.rx_data[22];
      end else if (w_issue_ack) begin
        r_ack_pending <= 1'b0;
      end

      r_rx_msg_valid <= w_rx_new;
      if (w_rx_new) begin
        r_rx_msg    <= lnk.rx_data[21:0];
        r_rx_expect <= ~r_rx_expect;
      end

      if (r_state == S_IDLE && w_grant_vld) begin
        r_winner  <= w_grant;
        r_rr_ptr  <= w_grant;
        r_payload <= w_grant ? lnk.req_data1 : lnk.req_data0;
      end

      if (w_issue_data)
        r_timer <= '0;
      else if (r_state == S_WAIT_ACK && r_timer != TIMER_SAT)
        r_timer <= r_timer + TW'(1);

      r_done <= {w_done_evt & r_winner, w_done_evt & ~r_winner};
      r_fail <= {w_fail_evt & r_winner, w_fail_evt & ~r_winner};

      if (w_done_evt || w_fail_evt) begin
        r_tx_seq  <= ~r_tx_seq;
        r_retries <= '0;
      end else if (w_retry_evt) begin
        r_retries <= r_retries + RW'(1);
      end
    end
  end

  assign lnk.send_tx      = r_send_tx;
  assign lnk.tx_data      = r_tx_data;
  assign lnk.done         = r_done;
  assign lnk.fail         = r_fail;
  assign lnk.rx_msg_valid = r_rx_msg_valid;
  assign lnk.rx_msg       = r_rx_msg;
  assign lnk.busy         = (r_state != S_IDLE);

`ifdef SPART_LINK_STATS_EN
  logic [15:0] r_stat_retries;
  logic [15:0] r_stat_drops;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_stat_retries <= '0;
      r_stat_drops   <= '0;
    end else begin
      if (w_retry_evt && r_stat_retries != 16'hFFFF) r_stat_retries <= r_stat_retries + 16'd1;
      if (w_fail_evt && r_stat_drops != 16'hFFFF)    r_stat_drops   <= r_stat_drops + 16'd1;
    end
  end

  assign stat_retries = r_stat_retries;
  assign stat_drops   = r_stat_drops;
`endif

endmodule

// File: tb/tb_spart_link_ctrl.sv
// Randomized bench for spart_link_ctrl against a transaction-level model of sequence bits,
// round-robin pointer and expected delivery, plus a monitor enforcing the launch rule.
module tb_spart_link_ctrl;
  localparam int TO = 100;
  localparam int MR = 3;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  spart_link_if lnk();

`ifdef SPART_LINK_STATS_EN
  logic [15:0] stat_retries;
  logic [15:0] stat_drops;
`endif

  spart_link_ctrl #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
`ifdef SPART_LINK_STATS_EN
    .stat_retries (stat_retries),
    .stat_drops   (stat_drops),
`endif
    .lnk          (lnk)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Model state: next TX sequence bit, expected RX sequence bit, last granted requester.
  logic m_seq, m_exp, m_rr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int   n_sends = 0, n_done_p = 0, n_fail_p = 0;
  logic prev_send = 1'b0;
  logic busy_at_edge;

  always @(posedge sys_clk) begin
    busy_at_edge = lnk.tx_busy;
    #1;
    if (lnk.send_tx) begin
      n_sends++;
      chk("issue_while_busy", {31'd0, busy_at_edge}, 0);
      chk("issue_back_to_back", {31'd0, prev_send}, 0);
    end
    if (lnk.done != 2'b00) n_done_p++;
    if (lnk.fail != 2'b00) n_fail_p++;
    prev_send = lnk.send_tx;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    lnk.req = 2'b00; lnk.rx_valid = 1'b0; lnk.rx_data = '0; lnk.tx_busy = 1'b0;
    lnk.req_data0 = '0; lnk.req_data1 = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst_send_tx", {31'd0, lnk.send_tx}, 0);
    chk("rst_tx_data", {8'd0, lnk.tx_data}, 0);
    chk("rst_done", {30'd0, lnk.done}, 0);
    chk("rst_fail", {30'd0, lnk.fail}, 0);
    chk("rst_busy", {31'd0, lnk.busy}, 0);
    chk("rst_rx_msg_valid", {31'd0, lnk.rx_msg_valid}, 0);
    chk("rst_rx_msg", {10'd0, lnk.rx_msg}, 0);
`ifdef SPART_LINK_STATS_EN
    chk("rst_stat_retries", {16'd0, stat_retries}, 0);
    chk("rst_stat_drops", {16'd0, stat_drops}, 0);
`endif
    rst_n = 1'b1;
    m_seq = 1'b0; m_exp = 1'b0; m_rr = 1'b0;
  endtask

  // Waits (bounded) for a launch; exp_lat of 0 means latency is not checked.
  task automatic expect_frame(input string tag, input int max_cyc, input int exp_lat, input logic [23:0] exp_frm);
    int lat = 0;
    do begin
      @(negedge sys_clk);
      lat++;
    end while (!lnk.send_tx && lat < max_cyc);
    chk({tag, "_sent"}, {31'd0, lnk.send_tx}, 1);
    if (exp_lat > 0) chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_frame"}, {8'd0, lnk.tx_data}, {8'd0, exp_frm});
  endtask

  task automatic inject(input logic [23:0] f);
    lnk.rx_valid = 1'b1;
    lnk.rx_data  = f;
    @(negedge sys_clk);
    lnk.rx_valid = 1'b0;
    lnk.rx_data  = 24'($urandom);
  endtask

  task automatic set_payload(input logic r, input logic [21:0] p);
    if (r) lnk.req_data1 = p;
    else   lnk.req_data0 = p;
  endtask

  task automatic ack_and_done(input string tag, input logic r);
    inject({1'b1, m_seq, 22'd0});
    chk({tag, "_done"}, {30'd0, lnk.done}, r ? 2 : 1);
    chk({tag, "_nofail"}, {30'd0, lnk.fail}, 0);
    chk({tag, "_idle"}, {31'd0, lnk.busy}, 0);
    lnk.req[r] = 1'b0;
    m_seq = ~m_seq;
  endtask

  task automatic serve_single(input string tag, input logic r, input int ack_delay, input logic wrong_first);
    logic [21:0] p = 22'($urandom);
    set_payload(r, p);
    set_payload(~r, 22'($urandom));
    lnk.req[r] = 1'b1;
    m_rr = r;
    expect_frame(tag, 5, 2, {1'b0, m_seq, p});
    repeat (ack_delay) @(negedge sys_clk);
    if (wrong_first) begin
      inject({1'b1, ~m_seq, 22'd0});
      chk({tag, "_wrongseq_ignored"}, {30'd0, lnk.done}, 0);
    end
    ack_and_done(tag, r);
  endtask

  initial begin
    logic [21:0] p0, p1, pg, po, p, last;
    logic        g, s, r;
    int          lat, snap_s, snap_d, snap_f;

    do_reset();
    chk("plan_start", {31'd0, lnk.busy}, 0);

    // Test-plan case: requester 0, payload 0ABCDE.
    lnk.req_data0 = 22'h0ABCDE; lnk.req = 2'b01; m_rr = 1'b0;
    expect_frame("plan_single", 5, 2, 24'h0ABCDE);
    inject(24'h800000);
    chk("plan_done", {30'd0, lnk.done}, 1);
    chk("plan_idle", {31'd0, lnk.busy}, 0);
    lnk.req = 2'b00; m_seq = 1'b1;

    for (int i = 0; i < 8; i++)
      serve_single("single", 1'($urandom_range(0, 1)), $urandom_range(0, 40), 1'($urandom_range(0, 1)));

    // Simultaneous requests: the one opposite the last grant wins.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) serve_single("pre", 1'($urandom_range(0, 1)), 0, 1'b0);
      p0 = 22'($urandom); p1 = 22'($urandom);
      lnk.req_data0 = p0; lnk.req_data1 = p1; lnk.req = 2'b11;
      g  = ~m_rr;
      pg = g ? p1 : p0;
      po = g ? p0 : p1;
      expect_frame("both_first", 5, 2, {1'b0, m_seq, pg});
      m_rr = g;
      ack_and_done("both_first", g);
      expect_frame("both_second", 5, 2, {1'b0, m_seq, po});
      m_rr = ~g;
      ack_and_done("both_second", ~g);
    end

    // No ACK: original plus MR retransmits, then fail. The SEND cycle makes spacing TO+1.
    do_reset();
    r = 1'($urandom_range(0, 1));
    p = 22'($urandom);
    set_payload(r, p);
    lnk.req[r] = 1'b1;
    snap_d = n_done_p;
    expect_frame("to_first", 5, 2, {1'b0, m_seq, p});
    for (int i = 0; i < MR; i++) expect_frame("to_retx", TO + 20, TO + 1, {1'b0, m_seq, p});
    lat = 0;
    do begin
      @(negedge sys_clk);
      lat++;
    end while (lnk.fail == 2'b00 && lnk.send_tx == 1'b0 && lat < TO + 20);
    chk("to_fail", {30'd0, lnk.fail}, r ? 2 : 1);
    chk("to_fail_lat", lat, TO);
    chk("to_no_done", n_done_p, snap_d);
`ifdef SPART_LINK_STATS_EN
    chk("stat_retries", {16'd0, stat_retries}, MR);
    chk("stat_drops", {16'd0, stat_drops}, 1);
`endif
    lnk.req[r] = 1'b0;
    m_seq = ~m_seq;
    serve_single("after_fail", 1'($urandom_range(0, 1)), 3, 1'b0);

    // Reset mid-transfer abandons the message silently.
    r = 1'($urandom_range(0, 1));
    p = 22'($urandom);
    set_payload(r, p);
    lnk.req[r] = 1'b1;
    expect_frame("abandon", 5, 2, {1'b0, m_seq, p});
    snap_d = n_done_p; snap_f = n_fail_p;
    do_reset();
    repeat (TO + 50) @(negedge sys_clk);
    chk("abandon_no_done", n_done_p, snap_d);
    chk("abandon_no_fail", n_fail_p, snap_f);

    // RX filter: new frame delivered once, duplicate re-ACKed only.
    do_reset();
    inject(24'h012345);
    chk("rx_first_valid", {31'd0, lnk.rx_msg_valid}, 1);
    chk("rx_first_msg", {10'd0, lnk.rx_msg}, 32'h012345);
    m_exp = 1'b1;
    expect_frame("rx_first_ack", 5, 1, 24'h800000);
    inject(24'h012345);
    chk("rx_dup_valid", {31'd0, lnk.rx_msg_valid}, 0);
    chk("rx_dup_msg", {10'd0, lnk.rx_msg}, 32'h012345);
    expect_frame("rx_dup_ack", 5, 1, 24'h800000);
    last = 22'h012345;
    for (int i = 0; i < 12; i++) begin
      s = 1'($urandom_range(0, 1));
      p = 22'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        snap_s = n_sends;
        inject({1'b1, s, p});
        chk("rx_ackfrm_valid", {31'd0, lnk.rx_msg_valid}, 0);
        repeat (4) @(negedge sys_clk);
        chk("rx_ackfrm_nosend", n_sends, snap_s);
        chk("rx_ackfrm_msg", {10'd0, lnk.rx_msg}, {10'd0, last});
      end else begin
        inject({1'b0, s, p});
        chk("rx_rand_valid", {31'd0, lnk.rx_msg_valid}, {31'd0, s == m_exp});
        if (s == m_exp) begin
          last  = p;
          m_exp = ~m_exp;
        end
        chk("rx_rand_msg", {10'd0, lnk.rx_msg}, {10'd0, last});
        expect_frame("rx_rand_ack", 5, 1, {1'b1, s, 22'd0});
      end
    end

    // Data arriving in WAIT_ACK while the shifter is busy; the later frame's ACK wins.
    do_reset();
    p = 22'($urandom);
    lnk.req_data0 = p; lnk.req = 2'b01; m_rr = 1'b0;
    expect_frame("wb_data", 5, 2, {1'b0, m_seq, p});
    snap_s = n_sends;
    lnk.tx_busy = 1'b1;
    p0 = 22'($urandom); p1 = 22'($urandom);
    inject({1'b0, 1'b0, p0});
    chk("wb_rx0_valid", {31'd0, lnk.rx_msg_valid}, 1);
    inject({1'b0, 1'b1, p1});
    chk("wb_rx1_valid", {31'd0, lnk.rx_msg_valid}, 1);
    chk("wb_rx1_msg", {10'd0, lnk.rx_msg}, {10'd0, p1});
    repeat (8) @(negedge sys_clk);
    chk("wb_hold_nosend", n_sends, snap_s);
    lnk.tx_busy = 1'b0;
    expect_frame("wb_ack", 5, 1, {1'b1, 1'b1, 22'd0});
    chk("wb_still_waiting", {31'd0, lnk.busy}, 1);
    snap_s = n_sends;
    repeat (3) @(negedge sys_clk);
    chk("wb_single_ack", n_sends, snap_s);
    ack_and_done("wb", 1'b0);

    // ACK landing exactly on the timeout cycle counts as done.
    for (int i = 0; i < 2; i++) begin
      r = 1'($urandom_range(0, 1));
      p = 22'($urandom);
      set_payload(r, p);
      lnk.req[r] = 1'b1;
      m_rr = r;
      expect_frame("race", 5, 2, {1'b0, m_seq, p});
      snap_s = n_sends; snap_f = n_fail_p;
      repeat (TO - 1) @(negedge sys_clk);
      ack_and_done("race", r);
      repeat (TO + 20) @(negedge sys_clk);
      chk("race_no_retx", n_sends, snap_s);
      chk("race_no_fail", n_fail_p, snap_f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end
endmodule
